// File: rtl/sfp_send_queue.sv
// sfp_send_queue: descriptor FIFO feeding the SFP dispatch stage.
// FWFT output with a registered head, sticky errors, occupancy.
//
// Ports:
//   ap_clk, ap_rst_n           clock, async active-low reset
//   wr_en, wr_data             push side
//   wr_full, wr_afull          registered full / almost-full
//   qune_send_vaild/_data/_ack head descriptor handshake
//   flush                      sync clear of contents (errors kept)
//   err_clr                    clear sticky errors (set wins)
//   occupancy                  entries held incl. head, 0..DEPTH
//   ovf_err, udf_err           sticky overflow / underflow
// Optional: define SFP_SEND_QUEUE_STAT_EN to add stat_push_cnt and
//   stat_pop_cnt (accepted push/pop counters, reset-only clear).

module sfp_send_queue #(
   parameter int DATA_W   = 64,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int AFULL_TH = 12
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_full,
   output logic              wr_afull,
   output logic              qune_send_vaild,
   output logic [DATA_W-1:0] qune_send_data,
   input  logic              qune_send_ack,
   input  logic              flush,
   input  logic              err_clr,
   output logic [ADDR_W:0]   occupancy,
   output logic              ovf_err,
`ifdef SFP_SEND_QUEUE_STAT_EN
   output logic [31:0]       stat_push_cnt,
   output logic [31:0]       stat_pop_cnt,
`endif
   output logic              udf_err
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_VALID = 1'b1
   } state_t;

   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LP_AFTH  = (ADDR_W+1)'(AFULL_TH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_occ;
   logic              r_full;
   logic              r_afull;
   state_t            r_state;
   logic              r_vld;
   logic [DATA_W-1:0] r_data;
   logic              r_ovf;
   logic              r_udf;

   logic              w_push;
   logic              w_pop;
   logic              w_ovf_set;
   logic              w_udf_set;
   logic [ADDR_W:0]   w_mcnt;
   logic              w_mnz;
   logic [ADDR_W:0]   w_occ_nxt;

   // Full is the registered flag, so an ack on the same edge cannot
   // make room for a push.
   assign w_push    = wr_en & ~r_full & ~flush;
   assign w_pop     = qune_send_ack & r_vld & ~flush;
   assign w_ovf_set = wr_en & r_full & ~flush;
   assign w_udf_set = qune_send_ack & ~r_vld & ~flush;

   // Entries sitting in the array behind the head register.
   assign w_mcnt = r_occ - {{ADDR_W{1'b0}}, r_vld};
   assign w_mnz  = (w_mcnt != '0);

   always_comb begin
      w_occ_nxt = r_occ;
      if (w_push && !w_pop)
         w_occ_nxt = r_occ + 1'b1;
      else if (w_pop && !w_push)
         w_occ_nxt = r_occ - 1'b1;
   end

   // Array has no reset; contents are don't-care until written.
   always_ff @(posedge ap_clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= wr_data;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_wr_ptr <= '0;
         r_occ    <= '0;
         r_full   <= 1'b0;
         r_afull  <= 1'b0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_occ    <= '0;
         r_full   <= 1'b0;
         r_afull  <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         r_occ   <= w_occ_nxt;
         r_full  <= (w_occ_nxt == LP_DEPTH);
         r_afull <= (w_occ_nxt >= LP_AFTH);
      end
   end

   // Head FSM: the head only loads from entries already in the
   // array, so a push into an empty queue shows one edge later.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state  <= S_EMPTY;
         r_vld    <= 1'b0;
         r_data   <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_state  <= S_EMPTY;
         r_vld    <= 1'b0;
         r_rd_ptr <= '0;
      end else begin
         unique case (r_state)
            S_EMPTY: begin
               if (w_mnz) begin
                  r_state  <= S_VALID;
                  r_vld    <= 1'b1;
                  r_data   <= r_mem[r_rd_ptr];
                  r_rd_ptr <= r_rd_ptr + 1'b1;
               end
            end
            S_VALID: begin
               if (w_pop) begin
                  if (w_mnz) begin
                     r_data   <= r_mem[r_rd_ptr];
                     r_rd_ptr <= r_rd_ptr + 1'b1;
                  end else begin
                     r_state <= S_EMPTY;
                     r_vld   <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= S_EMPTY;
               r_vld   <= 1'b0;
            end
         endcase
      end
   end

   // Sticky errors: a same-cycle set beats err_clr.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (w_ovf_set)
            r_ovf <= 1'b1;
         else if (err_clr)
            r_ovf <= 1'b0;
         if (w_udf_set)
            r_udf <= 1'b1;
         else if (err_clr)
            r_udf <= 1'b0;
      end
   end

`ifdef SFP_SEND_QUEUE_STAT_EN
   logic [31:0] r_push_cnt;
   logic [31:0] r_pop_cnt;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_push_cnt <= '0;
         r_pop_cnt  <= '0;
      end else begin
         if (w_push)
            r_push_cnt <= r_push_cnt + 1'b1;
         if (w_pop)
            r_pop_cnt <= r_pop_cnt + 1'b1;
      end
   end

   assign stat_push_cnt = r_push_cnt;
   assign stat_pop_cnt  = r_pop_cnt;
`endif

   assign wr_full         = r_full;
   assign wr_afull        = r_afull;
   assign qune_send_vaild = r_vld;
   assign qune_send_data  = r_data;
   assign occupancy       = r_occ;
   assign ovf_err         = r_ovf;
   assign udf_err         = r_udf;

endmodule

// File: tb/tb_sfp_send_queue.sv
// tb_sfp_send_queue: directed + random stimulus against a
// queue-based reference model of sfp_send_queue.

module tb_sfp_send_queue;

   localparam int DW    = 64;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int ATH   = 12;

   logic          ap_clk = 1'b0;
   logic          ap_rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_full;
   logic          wr_afull;
   logic          qune_send_vaild;
   logic [DW-1:0] qune_send_data;
   logic          qune_send_ack = 1'b0;
   logic          flush = 1'b0;
   logic          err_clr = 1'b0;
   logic [AW:0]   occupancy;
   logic          ovf_err;
   logic          udf_err;
`ifdef SFP_SEND_QUEUE_STAT_EN
   logic [31:0]   stat_push_cnt;
   logic [31:0]   stat_pop_cnt;
`endif

   sfp_send_queue #(
      .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .AFULL_TH(ATH)
   ) dut (
      .ap_clk(ap_clk),
      .ap_rst_n(ap_rst_n),
      .wr_en(wr_en),
      .wr_data(wr_data),
      .wr_full(wr_full),
      .wr_afull(wr_afull),
      .qune_send_vaild(qune_send_vaild),
      .qune_send_data(qune_send_data),
      .qune_send_ack(qune_send_ack),
      .flush(flush),
      .err_clr(err_clr),
      .occupancy(occupancy),
      .ovf_err(ovf_err),
`ifdef SFP_SEND_QUEUE_STAT_EN
      .stat_push_cnt(stat_push_cnt),
      .stat_pop_cnt(stat_pop_cnt),
`endif
      .udf_err(udf_err)
   );

   always #5 ap_clk = ~ap_clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: every held entry in arrival order, q[0] is
   // the oldest; m_vld says whether it is presented at the head.
   logic [DW-1:0] q [$];
   bit m_vld = 1'b0;
   bit m_ovf = 1'b0;
   bit m_udf = 1'b0;

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_vld = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   task automatic model_step(input bit we, input logic [DW-1:0] d,
                             input bit a, input bit f, input bit c);
      bit full;
      bit pop;
      bit ovf_set;
      bit udf_set;
      int stored;
      full = (q.size() == DEPTH);
      if (f) begin
         q.delete();
         m_vld = 1'b0;
         if (c) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
         end
         return;
      end
      pop     = a && m_vld;
      ovf_set = we && full;
      udf_set = a && !m_vld;
      stored  = q.size() - int'(m_vld);
      if (pop)
         void'(q.pop_front());
      if (we && !full)
         q.push_back(d);
      if (!(m_vld && !pop))
         m_vld = (stored > 0);
      if (ovf_set) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      if (udf_set) m_udf = 1'b1;
      else if (c) m_udf = 1'b0;
   endtask

   task automatic check_all();
      chk("occupancy", DW'(occupancy), DW'(q.size()));
      chk("wr_full", DW'(wr_full), DW'(q.size() == DEPTH));
      chk("wr_afull", DW'(wr_afull), DW'(q.size() >= ATH));
      chk("vaild", DW'(qune_send_vaild), DW'(m_vld));
      if (m_vld)
         chk("data", qune_send_data, q[0]);
      chk("ovf_err", DW'(ovf_err), DW'(m_ovf));
      chk("udf_err", DW'(udf_err), DW'(m_udf));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_occ"}, DW'(occupancy), '0);
      chk({tag, "_full"}, DW'(wr_full), '0);
      chk({tag, "_afull"}, DW'(wr_afull), '0);
      chk({tag, "_vld"}, DW'(qune_send_vaild), '0);
      chk({tag, "_data"}, qune_send_data, '0);
      chk({tag, "_ovf"}, DW'(ovf_err), '0);
      chk({tag, "_udf"}, DW'(udf_err), '0);
   endtask

   // Drive inputs just after an edge, model the next edge, then
   // check 1 time unit after it.
   task automatic cyc(input bit we, input logic [DW-1:0] d,
                      input bit a, input bit f, input bit c);
      wr_en         = we;
      wr_data       = d;
      qune_send_ack = a;
      flush         = f;
      err_clr       = c;
      @(posedge ap_clk);
      model_step(we, d, a, f, c);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic fill(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++)
         cyc(1'b1, base + DW'(i), 1'b0, 1'b0, 1'b0);
   endtask

   function automatic logic [DW-1:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      // Power-on reset
      #12;
      check_zero("rst");
      @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      model_reset();

      // Single descriptor: 2-cycle latency, then pop to empty
      cyc(1'b1, 64'hA5, 1'b0, 1'b0, 1'b0);
      chk("a5_lat_vld", DW'(qune_send_vaild), '0);
      idle(1);
      chk("a5_data", qune_send_data, 64'hA5);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle(1);

      // Fill to full, overflow, drain back-to-back
      fill(DEPTH, 64'd0);
      chk("full16", DW'(wr_full), 64'd1);
      cyc(1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b0);
      chk("ovf17", DW'(ovf_err), 64'd1);
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_order", qune_send_data, DW'(i));
         cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
      idle(1);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

      // Full with simultaneous push and ack: push dropped
      fill(DEPTH, 64'h100);
      cyc(1'b1, 64'hBEEF, 1'b1, 1'b0, 1'b0);
      chk("pp_full_occ", DW'(occupancy), 64'd15);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);

      // Steady occupancy 5 across pointer wrap
      fill(5, 64'h200);
      idle(1);
      for (int i = 0; i < 40; i++)
         cyc(1'b1, 64'h300 + DW'(i), 1'b1, 1'b0, 1'b0);
      chk("steady_occ", DW'(occupancy), 64'd5);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Underflow, clear, clear racing a new bad ack
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("udf_set", DW'(udf_err), 64'd1);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("udf_clr", DW'(udf_err), 64'd0);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
      chk("udf_setwins", DW'(udf_err), 64'd1);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

      // Flush with a same-cycle push
      fill(8, 64'h400);
      cyc(1'b1, 64'h4FF, 1'b0, 1'b1, 1'b0);
      chk("flush_occ", DW'(occupancy), 64'd0);
      chk("flush_ovf", DW'(ovf_err), 64'd0);
      idle(2);

      // Asynchronous reset mid-stream
      fill(6, 64'h500);
      cyc(1'b1, 64'h5FF, 1'b1, 1'b0, 1'b0);
      #2;
      ap_rst_n = 1'b0;
      #1;
      check_zero("arst");
      @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      model_reset();
      cyc(1'b1, 64'h600, 1'b0, 1'b0, 1'b0);
      chk("post_rst_occ", DW'(occupancy), 64'd1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 9) < 6, rnd64(),
             $urandom_range(0, 9) < 5,
             $urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < 5);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sfp_send_queue.md
# sfp_send_queue

Descriptor queue upstream of the SFP dispatch enable stage. Buffers send descriptors written by the host-side scheduler and presents the head entry with `qune_send_vaild`, which the dispatch stage samples under `kernel_send_start`. Output is first-word-fall-through with a registered head, so one descriptor can be popped per cycle. Sticky error flags and occupancy reporting support the control path.

## Interface
- `DATA_W`, 64, descriptor width in bits
- `DEPTH`, 16, total capacity in entries, including the head register; power of two, ≥4
- `ADDR_W`, 4, log2(DEPTH)
- `AFULL_TH`, 12, occupancy at or above which `wr_afull` asserts; 1..DEPTH
- `ap_clk`  in  1  sole clock; all logic on its rising edge
- `ap_rst_n`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  push `wr_data` this cycle
- `wr_data`  in  DATA_W  descriptor to push
- `wr_full`  out  1  occupancy == DEPTH (registered)
- `wr_afull`  out  1  occupancy >= AFULL_TH (registered)
- `qune_send_vaild`  out  1  head descriptor valid
- `qune_send_data`  out  DATA_W  head descriptor; held stable while `qune_send_vaild`=1 and no ack
- `qune_send_ack`  in  1  consumer took the head this cycle
- `flush`  in  1  synchronous clear of all contents
- `err_clr`  in  1  clears the sticky error flags
- `occupancy`  out  ADDR_W+1  entries held, 0..DEPTH
- `ovf_err`  out  1  sticky: push dropped because the queue was full
- `udf_err`  out  1  sticky: ack received with `qune_send_vaild`=0

## Operation
- Storage is an internal array plus a head register. `occupancy` counts both.
- Head state machine:
  - EMPTY: `qune_send_vaild`=0.
  - VALID: the head holds the oldest entry.
  - EMPTY→VALID: the head register loads the oldest stored entry on the edge after it is written.
  - VALID→VALID on ack: the next stored entry loads the same edge; `qune_send_vaild` stays 1 (back-to-back pops).
  - VALID→EMPTY on ack: occurs when no stored entry remains.
- Push is accepted when `wr_en`=1 and `wr_full`=0.
  - Push with `wr_full`=1 is dropped, storage is unchanged, and `ovf_err` is set. This holds even if `qune_send_ack` is 1 the same cycle; `full` is the registered value.
- Pop is accepted when `qune_send_ack`=1 and `qune_send_vaild`=1.
  - Ack with `qune_send_vaild`=0 is ignored and sets `udf_err`.
- Simultaneous accepted push and pop: occupancy unchanged.
- Pointers wrap modulo DEPTH. Occupancy is never wrapped; it saturates by construction at 0..DEPTH.
- `flush`=1 on an edge:
  - clears pointers, occupancy, `qune_send_vaild`, `wr_full` and `wr_afull`;
  - overrides a same-cycle push (dropped, no `ovf_err`) and a same-cycle ack (no `udf_err`);
  - leaves error flags untouched.
- `err_clr`=1 clears both flags. If an error event occurs in the same cycle, the set wins.
- Reset (asynchronous, any time, including mid-stream):
  - all outputs go to 0 (`qune_send_data`=0, `occupancy`=0, flags=0);
  - storage contents are don't-care;
  - state is EMPTY.

## Timing
- Push into an empty queue sampled at edge k: `qune_send_vaild`=1 after edge k+1 (2-cycle latency).
- `occupancy`, `wr_full` and `wr_afull` update at edge k, reflecting the push and pop accepted there.
- Pop at edge k with further entries stored: the new head is valid after edge k. Throughput is 1 pop per cycle.
- A pop at edge k clears `wr_full` after edge k; a push at edge k+1 is then accepted.
- Error flags assert after the edge that samples the offending event.
- Reset deassertion: the first push is accepted on the first rising edge with `ap_rst_n`=1.

## Configuration
- `SFP_SEND_QUEUE_STAT_EN` defined adds two outputs:
  - `stat_push_cnt` [31:0]: accepted pushes; wraps at 2^32.
  - `stat_pop_cnt` [31:0]: accepted pops; wraps at 2^32.
  - Both are cleared by reset only; `flush` does not clear them.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset, push 0xA5 at edge k → `qune_send_vaild`=1 and data=0xA5 after edge k+1, `occupancy`=1; ack → `vaild`=0, `occupancy`=0.
- Push 16 entries 0..15 with no ack → `wr_full`=1 at occupancy 16. `wr_afull` rises when occupancy reaches 12. A 17th push is dropped with `ovf_err`=1. Ack 16 times back-to-back → data 0..15 in order, `vaild` continuous.
- Occupancy 16 with push+ack on the same edge → push dropped, `ovf_err`=1, occupancy 15.
- Occupancy 5 with push+ack each cycle for 40 cycles → occupancy stays 5, FIFO order preserved across pointer wrap.
- Ack while empty → `udf_err`=1. `err_clr` → 0. `err_clr` in the same cycle as a new bad ack → `udf_err` stays 1.
- Occupancy 8, `flush` together with `wr_en` → occupancy 0, `vaild`=0, no `ovf_err`. `ap_rst_n` pulsed low mid-stream → all outputs 0 immediately, without waiting for a clock edge.
